// File: rtl/arc_mmio_bridge.sv
// MMIO bridge from the ARC 32-bit memory port to the 8-bit perifericos UART block.
// Stretches wr/rd strobes and the gap after them so the peripheral's debounced inputs see them.
module arc_mmio_bridge #(
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00,
  parameter int          HOLD_CYCLES = 1048576,
  parameter int          GAP_CYCLES  = 1048576,
  parameter int          CW          = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        busy,
  output logic        s_mmio,
  output logic        s_io,
  output logic        wr,
  output logic        rd,
  output logic [7:0]  data_in,
  input  logic [7:0]  data_out
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, ACK} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next;

  logic       we_q, dsel_q;
  logic [7:0] byte_q;

  logic       capture, hit_in;
  logic       we_n, dsel_n, active_n;
  logic [7:0] byte_n;

  logic unused_bits;
  assign unused_bits = ^{cpu_wdata[31:8], cpu_addr[1:0]};

  assign capture = (state == IDLE) && cpu_req;
  assign hit_in  = (cpu_addr[31:3] == MMIO_BASE[31:3]);

  // Captured access attributes as they will be after this edge, so the
  // registered outputs can already reflect a capture happening right now.
  assign we_n   = capture ? cpu_we         : we_q;
  assign dsel_n = capture ? ~cpu_addr[2]   : dsel_q;
  assign byte_n = capture ? cpu_wdata[7:0] : byte_q;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cpu_req) next_state = hit_in ? SETUP : ACK;
      SETUP:   next_state = dsel_q ? STROBE : ACK;
      STROBE:  if (cnt == HOLD_LAST) next_state = RELEASE;
      RELEASE: if (cnt == GAP_LAST) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase

    cnt_next = '0;
    if ((next_state == state) && ((state == STROBE) || (state == RELEASE)))
      cnt_next = cnt + CW'(1);

    active_n = (next_state == SETUP) || (next_state == STROBE) ||
               (next_state == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      dsel_q <= 1'b0;
      byte_q <= 8'h00;
    end else if (capture) begin
      we_q   <= cpu_we;
      dsel_q <= ~cpu_addr[2];
      byte_q <= cpu_wdata[7:0];
    end
  end

  // Outputs are registered from the next state, so each becomes visible in the
  // same cycle the FSM sits in the state that calls for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      busy    <= 1'b0;
      s_mmio  <= 1'b0;
      s_io    <= 1'b0;
      wr      <= 1'b0;
      rd      <= 1'b0;
      data_in <= 8'h00;
    end else begin
      cpu_ack <= (next_state == ACK);
      cpu_err <= capture && !hit_in;
      busy    <= (next_state != IDLE);
      s_mmio  <= active_n;
      s_io    <= active_n && dsel_n;
      wr      <= (next_state == STROBE) && we_n;
      rd      <= (next_state == STROBE) && !we_n;
      data_in <= (active_n && we_n) ? byte_n : 8'h00;
    end
  end

  // The peripheral mux has been driven for the whole SETUP cycle by now.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata <= 32'h0;
    end else if (capture) begin
      cpu_rdata <= 32'h0;
    end else if ((state == SETUP) && !we_q) begin
      cpu_rdata <= {24'h0, data_out};
    end
  end

endmodule
